// File: rtl/pcm_recorder.sv
// rtl/pcm_recorder.sv - fixed-rate PCM sample capture into an internal RAM with a registered read port
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   record     single-cycle pulse, starts or restarts a capture
//   stop       single-cycle pulse, ends a capture
//   in         live sample, taken only on tick cycles
//   rd_addr    physical RAM index to read
//   rd_data    registered mem[rd_addr], old data when the same address is written
//   recording  high while capturing
//   full       length == SAMPLES_SIZE
//   length     number of valid samples, saturating at SAMPLES_SIZE
//   head       physical index of the oldest valid sample
//   done       one-cycle pulse when a capture ends by stop or by filling up
module pcm_recorder #(
    parameter int SAMPLES_SIZE = 1024,
    parameter int SAMPLE_WIDTH = 8,
    parameter int CLK_FREQ     = 0,
    parameter int SAMPLE_FREQ  = 8000,
    parameter int WRAP         = 0,
    localparam int AW          = $clog2(SAMPLES_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    record,
    input  logic                    stop,
    input  logic [SAMPLE_WIDTH-1:0] in,
    input  logic [AW-1:0]           rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    recording,
    output logic                    full,
    output logic [AW:0]             length,
    output logic [AW-1:0]           head,
    output logic                    done
);

    localparam int DIV = CLK_FREQ / SAMPLE_FREQ;
    // Guarded so the default (unconfigured) CLK_FREQ still elaborates.
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [AW:0]   LEN_FULL = (AW + 1)'(SAMPLES_SIZE);
    localparam logic [AW:0]   LEN_LAST = (AW + 1)'(SAMPLES_SIZE - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REC  = 1'b1;

    logic [0:0]              state;
    logic [DW-1:0]           div_cnt;
    logic [AW-1:0]           wr_ptr;
    logic                    tick;
    logic                    mem_we;

    // Power-up contents are zero; neither rst nor record clears the RAM.
    logic [SAMPLE_WIDTH-1:0] mem [SAMPLES_SIZE] = '{default: '0};

    assign tick      = (state == ST_REC) && (div_cnt == DIV_LAST);
    // stop and record both outrank the tick, so either one suppresses the write.
    assign mem_we    = tick && !stop && !record;
    assign recording = (state == ST_REC);
    assign full      = (length == LEN_FULL);

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            wr_ptr  <= '0;
            length  <= '0;
            head    <= '0;
            done    <= 1'b0;
            rd_data <= '0;
        end else begin
            done    <= 1'b0;
            // Non-blocking read against the write block gives read-before-write.
            rd_data <= mem[rd_addr];

            if ((state == ST_REC) && stop) begin
                state <= ST_IDLE;
                done  <= 1'b1;
            end else if (record) begin
                state   <= ST_REC;
                div_cnt <= '0;
                wr_ptr  <= '0;
                length  <= '0;
                head    <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                wr_ptr  <= wr_ptr + AW'(1);
                if (!full) begin
                    length <= length + (AW + 1)'(1);
                end
                // Once wrapped, the oldest sample sits right after the newest one.
                if ((WRAP != 0) && full) begin
                    head <= wr_ptr + AW'(1);
                end
                if ((WRAP == 0) && (length == LEN_LAST)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end else if (state == ST_REC) begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pcm_recorder.sv
// tb/tb_pcm_recorder.sv - self-checking bench for pcm_recorder, one-shot and circular instances
module tb_pcm_recorder;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       record;
    logic       stop;
    logic [7:0] in_data;
    logic [1:0] rd_addr;

    logic [7:0] rd_data_s, rd_data_w;
    logic       recording_s, recording_w;
    logic       full_s, full_w;
    logic [2:0] length_s, length_w;
    logic [1:0] head_s, head_w;
    logic       done_s, done_w;

    int n_checks = 0;
    int n_fail   = 0;

    rd_exp_t exp_q[$];

    always #5 clk = ~clk;

    pcm_recorder #(
        .SAMPLES_SIZE(4), .SAMPLE_WIDTH(8), .CLK_FREQ(80), .SAMPLE_FREQ(10), .WRAP(0)
    ) u_shot (
        .clk(clk), .rst(rst), .record(record), .stop(stop), .in(in_data),
        .rd_addr(rd_addr), .rd_data(rd_data_s), .recording(recording_s), .full(full_s),
        .length(length_s), .head(head_s), .done(done_s)
    );

    pcm_recorder #(
        .SAMPLES_SIZE(4), .SAMPLE_WIDTH(8), .CLK_FREQ(80), .SAMPLE_FREQ(10), .WRAP(1)
    ) u_wrap (
        .clk(clk), .rst(rst), .record(record), .stop(stop), .in(in_data),
        .rd_addr(rd_addr), .rd_data(rd_data_w), .recording(recording_w), .full(full_w),
        .length(length_w), .head(head_w), .done(done_w)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_reads(input bit use_wrap, input string name);
        rd_exp_t    e;
        logic [7:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            next_cycle();
            got = use_wrap ? rd_data_w : rd_data_s;
            n_checks++;
            if (got !== e.data) begin
                n_fail++;
                $display("FAIL %s read addr %0d: got %02h expected %02h", name, e.addr, got, e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; record = 1'b0; stop = 1'b0; in_data = 8'h00; rd_addr = 2'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        n_checks++;
        if ({recording_s, full_s, length_s, head_s, done_s, rd_data_s} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_shot: rec=%b full=%b len=%0d head=%0d done=%b rd=%02h expected all 0",
                     recording_s, full_s, length_s, head_s, done_s, rd_data_s);
        end
        n_checks++;
        if ({recording_w, full_w, length_w, head_w, done_w, rd_data_w} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_wrap: rec=%b full=%b len=%0d head=%0d done=%b rd=%02h expected all 0",
                     recording_w, full_w, length_w, head_w, done_w, rd_data_w);
        end
    endtask

    task automatic test_one_shot();
        record = 1'b1; in_data = 8'h00;
        next_cycle();
        record = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            in_data = 8'(c);
            if (c % 8 == 0) exp_q.push_back('{addr: 2'(c / 8 - 1), data: 8'(c)});
            n_checks++;
            if (recording_s !== 1'b1 || done_s !== 1'b0) begin
                n_fail++;
                $display("FAIL one_shot_busy cycle %0d: rec=%b done=%b expected rec=1 done=0", c, recording_s, done_s);
            end
            next_cycle();
        end
        in_data = 8'h00;
        n_checks++;
        if ({recording_s, full_s, length_s, head_s, done_s} !== {1'b0, 1'b1, 3'd4, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL one_shot_end: rec=%b full=%b len=%0d head=%0d done=%b expected rec=0 full=1 len=4 head=0 done=1",
                     recording_s, full_s, length_s, head_s, done_s);
        end
        next_cycle();
        n_checks++;
        if (done_s !== 1'b0 || full_s !== 1'b1) begin
            n_fail++;
            $display("FAIL one_shot_done_pulse: done=%b full=%b expected done=0 full=1", done_s, full_s);
        end
        drain_reads(1'b0, "one_shot");
    endtask

    task automatic test_circular();
        logic [7:0] model [4];
        record = 1'b1; in_data = 8'h00;
        next_cycle();
        record = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            in_data = 8'((c - 1) / 8 + 1);
            if (c % 8 == 0) model[(c / 8 - 1) % 4] = in_data;
            n_checks++;
            if (recording_w !== 1'b1 || done_w !== 1'b0) begin
                n_fail++;
                $display("FAIL circular_busy cycle %0d: rec=%b done=%b expected rec=1 done=0", c, recording_w, done_w);
            end
            next_cycle();
        end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        n_checks++;
        if ({recording_w, full_w, length_w, head_w, done_w} !== {1'b0, 1'b1, 3'd4, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL circular_stop: rec=%b full=%b len=%0d head=%0d done=%b expected rec=0 full=1 len=4 head=2 done=1",
                     recording_w, full_w, length_w, head_w, done_w);
        end
        next_cycle();
        n_checks++;
        if (done_w !== 1'b0) begin
            n_fail++;
            $display("FAIL circular_single_done: done=%b expected 0", done_w);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 2'(i), data: model[i]});
        drain_reads(1'b1, "circular");
    endtask

    task automatic test_early_stop();
        record = 1'b1; in_data = 8'h00;
        next_cycle();
        record = 1'b0;
        repeat (19) next_cycle();
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        n_checks++;
        if ({recording_s, full_s, length_s, done_s} !== {1'b0, 1'b0, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL early_stop: rec=%b full=%b len=%0d done=%b expected rec=0 full=0 len=2 done=1",
                     recording_s, full_s, length_s, done_s);
        end
        next_cycle();
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        n_checks++;
        if (done_s !== 1'b0 || recording_s !== 1'b0 || length_s !== 3'd2) begin
            n_fail++;
            $display("FAIL idle_stop: done=%b rec=%b len=%0d expected done=0 rec=0 len=2", done_s, recording_s, length_s);
        end
    endtask

    task automatic test_restart();
        record = 1'b1; in_data = 8'h00;
        next_cycle();
        record = 1'b0;
        repeat (24) next_cycle();
        n_checks++;
        if (length_s !== 3'd3 || recording_s !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pre: len=%0d rec=%b expected len=3 rec=1", length_s, recording_s);
        end
        next_cycle();
        record = 1'b1;
        next_cycle();
        record = 1'b0;
        n_checks++;
        if ({recording_s, length_s, done_s} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL restart: rec=%b len=%0d done=%b expected rec=1 len=0 done=0", recording_s, length_s, done_s);
        end
        repeat (7) next_cycle();
        in_data = 8'hA5;
        exp_q.push_back('{addr: 2'd0, data: 8'hA5});
        n_checks++;
        if (length_s !== 3'd0) begin
            n_fail++;
            $display("FAIL restart_early_tick: len=%0d expected 0", length_s);
        end
        next_cycle();
        in_data = 8'h00;
        n_checks++;
        if (length_s !== 3'd1) begin
            n_fail++;
            $display("FAIL restart_tick: len=%0d expected 1", length_s);
        end
        drain_reads(1'b0, "restart");
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
    endtask

    task automatic test_simultaneous();
        // stop and record together while recording
        record = 1'b1;
        next_cycle();
        record = 1'b0;
        repeat (3) next_cycle();
        stop = 1'b1; record = 1'b1;
        next_cycle();
        stop = 1'b0; record = 1'b0;
        n_checks++;
        if ({recording_s, done_s} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL stop_and_record: rec=%b done=%b expected rec=0 done=1", recording_s, done_s);
        end
        // stop on a tick cycle must not write
        record = 1'b1;
        next_cycle();
        record = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            in_data = (c == 8) ? 8'h3C : (c == 16) ? 8'h4D : 8'h00;
            next_cycle();
        end
        in_data = 8'h00;
        record = 1'b1;
        next_cycle();
        record = 1'b0;
        repeat (7) next_cycle();
        in_data = 8'h77; stop = 1'b1;
        next_cycle();
        in_data = 8'h00; stop = 1'b0;
        n_checks++;
        if ({recording_s, length_s, done_s} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL stop_on_tick: rec=%b len=%0d done=%b expected rec=0 len=0 done=1", recording_s, length_s, done_s);
        end
        exp_q.push_back('{addr: 2'd0, data: 8'h3C});
        exp_q.push_back('{addr: 2'd1, data: 8'h4D});
        drain_reads(1'b0, "stop_on_tick");
        // reset in the middle of a capture
        record = 1'b1;
        next_cycle();
        record = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            in_data = (c == 8) ? 8'h5A : 8'h00;
            next_cycle();
        end
        in_data = 8'h00;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        n_checks++;
        if ({recording_s, full_s, length_s, head_s, done_s, rd_data_s} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_capture: rec=%b full=%b len=%0d head=%0d done=%b rd=%02h expected all 0",
                     recording_s, full_s, length_s, head_s, done_s, rd_data_s);
        end
        next_cycle();
        n_checks++;
        if (done_s !== 1'b0 || recording_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: done=%b rec=%b expected 0 0", done_s, recording_s);
        end
        exp_q.push_back('{addr: 2'd0, data: 8'h5A});
        drain_reads(1'b0, "reset_keeps_ram");
    endtask

    task automatic test_read_before_write();
        rd_addr = 2'd0;
        n_checks++;
        if (length_s !== 3'd0 || recording_s !== 1'b0) begin
            n_fail++;
            $display("FAIL rbw_idle: len=%0d rec=%b expected len=0 rec=0", length_s, recording_s);
        end
        record = 1'b1;
        next_cycle();
        record = 1'b0;
        repeat (7) next_cycle();
        in_data = 8'hE1;
        next_cycle();
        in_data = 8'h00;
        n_checks++;
        if (rd_data_s !== 8'h5A || length_s !== 3'd1) begin
            n_fail++;
            $display("FAIL rbw_old: rd=%02h len=%0d expected rd=5a len=1", rd_data_s, length_s);
        end
        next_cycle();
        n_checks++;
        if (rd_data_s !== 8'hE1) begin
            n_fail++;
            $display("FAIL rbw_new: rd=%02h expected e1", rd_data_s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected the test sequence to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_shot();
        test_circular();
        test_early_stop();
        test_restart();
        test_simultaneous();
        test_read_before_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcm_recorder.md
# pcm_recorder

Captures a live PCM sample stream (microphone front end, synthesizer bus, or a `pcm_player` output under test) into an internal sample RAM at a fixed sample rate. It is the write-side counterpart of the ROM-backed PCM playback path. Captured data is exposed through a registered random-access read port for playback, loopback checking or debug readout. It supports one-shot capture, which stops when the RAM is full, or circular capture, which keeps the most recent `SAMPLES_SIZE` samples.

## Interface
Parameters:
- `SAMPLES_SIZE`, 1024: RAM depth in samples; power of two ≥ 2. Define `AW = $clog2(SAMPLES_SIZE)`.
- `SAMPLE_WIDTH`, 8: bits per sample.
- `CLK_FREQ`, 0: clock frequency in Hz; must be overridden.
- `SAMPLE_FREQ`, 8000: capture rate in Hz. Define `DIV = CLK_FREQ / SAMPLE_FREQ`, integer-truncated, with `DIV ≥ 2`.
- `WRAP`, 0: 0 = one-shot, 1 = circular overwrite.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `record` input 1: single-cycle pulse; starts or restarts a capture.
- `stop` input 1: single-cycle pulse; ends a capture.
- `in` input `SAMPLE_WIDTH`: live sample; sampled only on tick cycles.
- `rd_addr` input `AW`: read address (physical RAM index).
- `rd_data` output `SAMPLE_WIDTH`: registered `mem[rd_addr]`.
- `recording` output 1: high while capturing.
- `full` output 1: `length == SAMPLES_SIZE`.
- `length` output `AW+1`: number of valid samples, saturating at `SAMPLES_SIZE`.
- `head` output `AW`: physical index of the oldest valid sample. Always 0 when `WRAP=0`; equals the write pointer once wrapped when `WRAP=1`.
- `done` output 1: one-cycle pulse when a capture ends.

## Operation
State machine:
- Two states, IDLE and REC. `recording` is 1 exactly in REC.

Internal registers:
- `div_cnt` counts 0..DIV-1 while in REC. A tick occurs in the cycle where `div_cnt == DIV-1`; `div_cnt` then returns to 0.
- `wr_ptr` (`AW` bits) is the next write address.

Event priority each cycle: `rst` > `stop` > `record` > tick.
- **`stop` in REC:** go to IDLE, pulse `done` next cycle. `length`, `head` and RAM are retained. No write occurs that cycle, even if it is a tick cycle.
- **`stop` in IDLE:** no effect, no `done`.
- **`record`, from either state:** go to REC. Clear `div_cnt`, `wr_ptr`, `length`, `head` and `full`. If already in REC, the capture restarts and no `done` is produced.
- **Tick in REC:**
  - Write `in` to `mem[wr_ptr]` and increment `wr_ptr` modulo `SAMPLES_SIZE`.
  - If `length < SAMPLES_SIZE`, increment `length`.
  - If `WRAP=1` and `length` was already `SAMPLES_SIZE` before this tick, `head` takes the new `wr_ptr`.
  - If `WRAP=0` and `length` reaches `SAMPLES_SIZE`, go to IDLE and pulse `done` next cycle.
  - If `WRAP=1`, capture continues until `stop`.

Read port:
- `rd_data` is registered from `mem[rd_addr]`.
- A read of the address being written in the same cycle returns the old contents (read-before-write).
- The read port works in both states.

RAM contents:
- Initialized to 0 at configuration.
- Not cleared by `rst` or `record`.

Width rules:
- `length` is `AW+1` bits so it can hold `SAMPLES_SIZE`.
- `wr_ptr` and `head` wrap naturally at `2^AW`.

## Timing
- **Reset values:** `recording`=0, `full`=0, `length`=0, `head`=0, `done`=0, `rd_data`=0. Internal `wr_ptr`=0 and `div_cnt`=0.
- **Start:** `record` asserted in cycle t → `recording`=1 in t+1.
- **First tick:** occurs in cycle t+DIV, capturing `in` as presented in that cycle. Sample k (from 0) is captured in cycle t+(k+1)·DIV.
- **Write visibility:** a write in cycle c updates `length`/`full`/`head` in c+1. The data is readable via `rd_data` in c+2 (set `rd_addr` in c+1).
- **One-shot end:** the final tick in cycle c → `recording`=0, `full`=1 and `done`=1 in c+1. `done`=0 in c+2.
- **Stop:** `stop` in cycle c → `recording`=0 and `done`=1 in c+1.
- **Read latency:** `rd_addr` presented in cycle c → `rd_data` valid in c+1.
- **Reset mid-capture:** IDLE next cycle, all outputs at reset values, no `done`. RAM keeps any samples already written.

## Test plan
All tests use `CLK_FREQ=80`, `SAMPLE_FREQ=10` (DIV=8), `SAMPLES_SIZE=4`, `SAMPLE_WIDTH=8`.
- **One-shot capture:** `WRAP=0`; `in` increments every cycle starting at 0x00 on the `record` cycle t. Expect captures at t+8, t+16, t+24, t+32 of values 0x08, 0x10, 0x18, 0x20. In t+33 expect `full`=1, `length`=4, `recording`=0, `done` pulse. Reading addresses 0..3 returns 08, 10, 18, 20.
- **Circular overwrite:** `WRAP=1`; `in` = sample index 1..6 on successive ticks, then `stop`. Expect `length`=4, `head`=2, mem = {05, 06, 03, 04}, a single `done` after `stop`.
- **Early stop:** `stop` 20 cycles after `record`. Expect `length`=2, `full`=0, `done` in the next cycle. A second `stop` while idle produces no `done`.
- **Restart:** `record` during REC with `length`=3. Next cycle `length`=0, `recording` stays 1, no `done`. The next capture lands 8 cycles after the restart, at address 0.
- **Simultaneous events and reset:**
  - `stop` and `record` in the same cycle: stop wins, giving IDLE plus `done`.
  - `stop` on a tick cycle: no write occurs.
  - `rst` mid-capture: all outputs 0, no `done`.
- **Read-before-write:** in IDLE with `length` 0, set `rd_addr`=0. Start a capture and check that the tick cycle writing address 0 returns the old value, and that the next cycle returns the new one.
